axi_write_master: RTL
=====================

AXI_WRITE_MASTER -- requirements
Module: axi_write_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width; strobe width DATA_W/8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle request pulse; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  burst start address.
REQ-007 start_len  input  8  AXI length (beats-1).
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse on B handshake.
REQ-010 err  output  1  sticky; set on bresp!=0; cleared by next accepted start.
REQ-011 din / din_valid / din_ready  input DATA_W / input 1 / output 1  beat source, valid/ready handshake.
REQ-012 awaddr ADDR_W, awlen 8, awsize 3, awburst 2, awvalid 1  outputs; awready 1 input.
REQ-013 wdata DATA_W, wstrb DATA_W/8, wlast 1, wvalid 1  outputs; wready 1 input.
REQ-014 bresp 2, bvalid 1  inputs; bready 1 output.

Function
REQ-015 SHALL implement FSM IDLE -> AW -> W -> B -> IDLE.
REQ-016 IDLE: start=1 latches start_addr/start_len into registers, clears err, enters AW next cycle.
REQ-017 AW: awvalid=1, awaddr/awlen from latched registers, awsize=2, awburst=2'b01; on awvalid&&awready enter W.
REQ-018 awvalid SHALL stay high and awaddr/awlen/awsize/awburst stable until the AW handshake.
REQ-019 W SHALL NOT start (wvalid=0) before AW handshake completes.
REQ-020 W: one-entry holding register; din_ready = (state==W) && (holding empty || (wvalid&&wready)) && beats remaining to fetch.
REQ-021 wvalid = holding register full; wdata = holding register; wstrb all ones whenever wvalid.
REQ-022 wvalid SHALL stay high and wdata/wstrb/wlast stable until wvalid&&wready.
REQ-023 8-bit beat counter cleared on AW handshake, incremented per W handshake; wlast=1 exactly when counter==latched awlen and wvalid=1.
REQ-024 awlen=0: first beat carries wlast=1.
REQ-025 W handshake with wlast=1 enters B; no further din accepted.
REQ-026 Back-to-back beats SHALL sustain one beat per cycle when din_valid and wready both stay high.
REQ-027 B: bready=1; on bvalid&&bready pulse done, set err if bresp!=0, return to IDLE.
REQ-028 busy = (state!=IDLE).
REQ-029 start while busy SHALL be ignored (no effect on registers or FSM).
REQ-030 bvalid, wready, awready outside the relevant state SHALL be ignored.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE and all outputs to 0 (awvalid, wvalid, wlast, bready, din_ready, busy, done, err, awaddr, awlen, wdata, wstrb; awsize=0, awburst=0 outside AW); holding register empty; counter 0.
REQ-032 reset mid-burst SHALL abort without completing outstanding beats; first cycle after release is IDLE.

Verification
REQ-033 start addr=0x100 len=3, awready delayed 3 cycles, wready/din_valid=1 -> awaddr stable 0x100 during wait; 4 beats, wlast on 4th; done 1 cycle after bvalid.
REQ-034 start len=0 -> single beat with wlast=1 on first wvalid; done after B.
REQ-035 len=7, wready toggled 1/0 randomly, din_valid gaps -> wdata/wlast stable while stalled; exactly 8 handshakes; din order preserved.
REQ-036 bresp=2'b10 on B -> err=1 after done; next start clears err to 0.
REQ-037 start pulsed while in W -> ignored; burst finishes unchanged.
REQ-038 reset=0 asserted during beat 2 of len=5 -> all outputs 0 immediately; new start after release runs full burst correctly.

Source files
------------

// File: rtl/axi_write_master.sv
// Single-burst AXI4 write master: latches a start request, issues one AW beat,
// streams len+1 data beats from a valid/ready source, then waits for the B response.
module axi_write_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [7:0]          start_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic [DATA_W-1:0]   din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [8:0]        fetch_cnt_q, fetch_cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic aw_hs;
    logic w_hs;
    logic din_hs;
    logic b_hs;
    logic last_beat;
    logic fetch_left;

    // fetch_cnt is 9 bits so a 256-beat burst can still tell "all fetched" apart from zero.
    always_comb begin
        aw_hs      = (state_q == S_AW) && awready;
        w_hs       = (state_q == S_W) && hold_full_q && wready;
        b_hs       = (state_q == S_B) && bvalid;
        last_beat  = hold_full_q && (beat_cnt_q == len_q);
        fetch_left = (fetch_cnt_q <= {1'b0, len_q});
        din_ready  = (state_q == S_W) && (!hold_full_q || w_hs) && fetch_left;
        din_hs     = din_ready && din_valid;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        beat_cnt_d  = beat_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = start_addr;
                    len_d   = start_len;
                    err_d   = 1'b0;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    beat_cnt_d  = 8'd0;
                    fetch_cnt_d = 9'd0;
                    hold_full_d = 1'b0;
                    state_d     = S_W;
                end
            end
            S_W: begin
                // A beat can be refilled in the same cycle it drains, giving full throughput.
                hold_full_d = din_hs || (hold_full_q && !w_hs);
                if (din_hs) begin
                    hold_data_d = din;
                    fetch_cnt_d = fetch_cnt_q + 9'd1;
                end
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last_beat) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (b_hs) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            beat_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            beat_cnt_q  <= beat_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    // Address-channel fields read as zero outside AW so an idle bus is quiet.
    always_comb begin
        awvalid = (state_q == S_AW);
        awaddr  = awvalid ? addr_q : '0;
        awlen   = awvalid ? len_q : '0;
        awsize  = awvalid ? 3'd2 : 3'd0;
        awburst = awvalid ? 2'b01 : 2'b00;
        wvalid  = hold_full_q;
        wdata   = hold_full_q ? hold_data_q : '0;
        wstrb   = {STRB_W{hold_full_q}};
        wlast   = last_beat;
        bready  = (state_q == S_B);
        busy    = (state_q != S_IDLE);
        done    = done_q;
        err     = err_q;
    end

endmodule
